l2_arbiter: RTL and testbench
=============================

Name: l2_arbiter

Overview:
- Round-robin arbiter and transaction sequencer that shares the single framebuffer (fb) port among N_CORES requesting cores.
- Sits between the per-core request ports and the fb memory. Grants one core at a time and holds the grant for the whole transaction.
- On writes, broadcasts an invalidate to every core and collects the acknowledgements before completing.
- Returns read data and a one-cycle ready to the granted core.

Parameters:
- N_REQ, default N_CORES: number of requesters; ports are unpacked arrays of this size.
- RR_RESET, default 0: value of the round-robin pointer after reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-low.
- en[N_REQ]  in  1 each  request valid; held until that core's ready.
- w[N_REQ]  in  1 each  1 = write, 0 = read.
- addr[N_REQ]  in  fb_addr_t each  request address.
- d_in[N_REQ]  in  fb_word_t each  write data.
- d_out[N_REQ]  out  fb_word_t each  read data; valid while that core's ready is high.
- ready[N_REQ]  out  1 each  one-cycle completion pulse.
- invalidate[N_REQ]  out  1 each  invalidate request to each core.
- inv_addr  out  fb_addr_t  address being invalidated.
- invalidated[N_REQ]  in  1 each  invalidate acknowledge.
- fb_en, fb_w  out  1  fb request valid and write flag.
- fb_addr  out  fb_addr_t  fb address.
- fb_in  out  fb_word_t  fb write data.
- fb_out  in  fb_word_t  fb read data.
- fb_ready  in  1  fb completion, one cycle.
- grant  out  core_id_t  currently granted core.
- busy  out  1  transaction in flight.

Behaviour:
- Reset (asynchronous, rst low):
  - State goes to IDLE and the pointer to RR_RESET.
  - All outputs go to 0: fb_en, fb_w, fb_addr, fb_in, ready, invalidate, inv_addr, d_out, grant, busy.
  - An in-flight fb transaction is abandoned; a later fb_ready is ignored.
- States: IDLE, FB, INVAL, RESP.
- IDLE:
  - Scan en starting at the pointer, ascending with wrap modulo N_REQ; the first asserted en wins.
  - On the winning edge, latch grant, w, addr and d_in into registers and go to FB. busy is 1 from the next cycle.
  - With no en asserted, stay in IDLE.
- FB:
  - fb_en=1; fb_w, fb_addr and fb_in are driven from the latched values.
  - Latency: fb_en rises exactly 1 cycle after the edge on which the request was sampled.
  - On an edge with fb_ready=1: drop fb_en and latch fb_out into the data register (reads only).
  - Next state is INVAL if the latched w=1, else RESP.
- INVAL:
  - invalidate[i]=1 for all i; inv_addr = latched addr.
  - A sticky ack mask is cleared on entry. Bit i sets when invalidated[i]=1; acks may arrive in any cycle, in any order.
  - When the mask is all-ones, or all acks arrive in the entry cycle, drop invalidate and go to RESP.
- RESP:
  - ready[grant]=1 for exactly one cycle; d_out[grant] = latched data (0 for writes). All other ready and d_out stay 0.
  - Next state IDLE; pointer = grant+1 mod N_REQ.
- Requester rule: a core drops en in its ready cycle.
  - IDLE samples en no earlier than the cycle after RESP, so a core cannot be re-granted off a stale en.
- Changes to en, addr, w or d_in of the granted core after the grant are ignored until RESP.
- fb_ready outside FB is ignored. invalidated outside INVAL is ignored.
- Simultaneous requests are all served in rotation order; no core is starved beyond N_REQ-1 transactions.

Optional Feature:
- Macro: L2ARB_SKIP_SELF_INV_EN.
- Defined:
  - The writing core receives no invalidate.
  - Its mask bit is preset to 1 on entry to INVAL.
  - With N_REQ=1, INVAL lasts one cycle.
- Undefined: all cores, including the writer, are invalidated and must acknowledge.

Decomposition:
- Package cache_attrs holds:
  - fb_addr_t and fb_word_t.
  - core_id_t, width $clog2(N_CORES).
  - the arbiter state enum l2arb_state_t.
- One sub-module, rr_pick: combinational round-robin priority select.
  - Inputs: request vector and pointer.
  - Outputs: winner index and valid flag.

Test Plan:
1. Single read: en[0]=1, w=0, addr=17; fb_ready 3 cycles after fb_en with fb_out=0x6768697071727374 -> fb_en 1 cycle after request with fb_w=0, fb_addr=17; ready[0] for one cycle with d_out[0]=0x6768697071727374; grant=0.
2. Write with invalidation: en[1]=1, w=1, addr=243, d_in=0xdeadbeeffeddeeda -> fb_w=1 and fb_in=0xdeadbeeffeddeeda. After fb_ready, invalidate all high with inv_addr=243. Acks in order 2,0,1 on separate cycles -> ready[1] only on the cycle after the last ack.
3. Concurrent reads: en[0..2]=1 at addrs 123, 321, 555; fb_out=fb_addr each time -> served in order 0,1,2; each d_out[i]=addr[i]; exactly 3 fb_en bursts.
4. Fairness: pointer at 1, en[0] and en[2] both held -> grant 2 first, then 0.
5. Reset mid-FB: rst low while fb_en=1 -> all outputs 0 immediately; a later fb_ready produces no ready.
6. Macro on: core 2 writes -> invalidate[2]=0; only acks 0 and 1 are needed before ready[2].

Source files
------------

// File: rtl/cache_attrs_pkg.sv
// Shared types for the L2 framebuffer arbiter: fb address/word, core id and
// the arbiter state encoding.
package cache_attrs;

  localparam int N_CORES   = 3;
  localparam int FB_ADDR_W = 16;
  localparam int FB_WORD_W = 64;

  typedef logic [FB_ADDR_W-1:0]       fb_addr_t;
  typedef logic [FB_WORD_W-1:0]       fb_word_t;
  typedef logic [$clog2(N_CORES)-1:0] core_id_t;

  typedef enum logic [1:0] {
    IDLE,
    FB,
    INVAL,
    RESP
  } l2arb_state_t;

endpackage

// File: rtl/l2_arbiter_rr_pick.sv
// Combinational round-robin select: first asserted request at or after the
// pointer, scanning upward with wrap.
module rr_pick #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] winner_o,
  output logic          valid_o
);

  always_comb begin
    winner_o = '0;
    valid_o  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!valid_o && req_i[(int'(ptr_i) + i) % N]) begin
        valid_o  = 1'b1;
        winner_o = IW'((int'(ptr_i) + i) % N);
      end
    end
  end

endmodule

// File: rtl/l2_arbiter.sv
// Round-robin arbiter/sequencer sharing one framebuffer port among cores.
// Define L2ARB_SKIP_SELF_INV_EN to exempt the writing core from invalidation.
module l2_arbiter
  import cache_attrs::*;
#(
  parameter int N_REQ    = N_CORES,
  parameter int RR_RESET = 0
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     en          [N_REQ],
  input  logic     w           [N_REQ],
  input  fb_addr_t addr        [N_REQ],
  input  fb_word_t d_in        [N_REQ],
  output fb_word_t d_out       [N_REQ],
  output logic     ready       [N_REQ],
  output logic     invalidate  [N_REQ],
  output fb_addr_t inv_addr,
  input  logic     invalidated [N_REQ],
  output logic     fb_en,
  output logic     fb_w,
  output fb_addr_t fb_addr,
  output fb_word_t fb_in,
  input  fb_word_t fb_out,
  input  logic     fb_ready,
  output core_id_t grant,
  output logic     busy
);

  l2arb_state_t     state_q;
  core_id_t         ptr_q;
  core_id_t         grant_q;
  logic             w_q;
  fb_addr_t         addr_q;
  fb_word_t         din_q;
  logic [N_REQ-1:0] mask_q;
  logic             fb_en_q;
  logic [N_REQ-1:0] ready_q;
  logic [N_REQ-1:0] inv_q;
  fb_addr_t         inv_addr_q;
  logic             busy_q;
  fb_word_t         d_out_q [N_REQ];

  logic [N_REQ-1:0] req_vec;
  logic [N_REQ-1:0] ack_vec;
  logic [N_REQ-1:0] grant_oh;
  logic [N_REQ-1:0] mask_d;
  logic [N_REQ-1:0] inv_init;
  logic [N_REQ-1:0] mask_init;
  core_id_t         pick_id;
  logic             pick_vld;

  always_comb begin
    req_vec  = '0;
    ack_vec  = '0;
    grant_oh = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_vec[i]  = en[i];
      ack_vec[i]  = invalidated[i];
      grant_oh[i] = (grant_q == core_id_t'(i));
    end
    mask_d = mask_q | ack_vec;
  end

`ifdef L2ARB_SKIP_SELF_INV_EN
  assign inv_init  = ~grant_oh;
  assign mask_init = grant_oh;
`else
  assign inv_init  = '1;
  assign mask_init = '0;
`endif

  rr_pick #(
    .N  (N_REQ),
    .IW ($bits(core_id_t))
  ) u_pick (
    .req_i    (req_vec),
    .ptr_i    (ptr_q),
    .winner_o (pick_id),
    .valid_o  (pick_vld)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      ptr_q      <= core_id_t'(RR_RESET);
      grant_q    <= '0;
      w_q        <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      mask_q     <= '0;
      fb_en_q    <= 1'b0;
      ready_q    <= '0;
      inv_q      <= '0;
      inv_addr_q <= '0;
      busy_q     <= 1'b0;
      for (int i = 0; i < N_REQ; i++) d_out_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            grant_q <= pick_id;
            w_q     <= w[pick_id];
            addr_q  <= addr[pick_id];
            din_q   <= d_in[pick_id];
            fb_en_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= FB;
          end
        end
        FB: begin
          if (fb_ready) begin
            fb_en_q <= 1'b0;
            if (w_q) begin
              inv_q      <= inv_init;
              inv_addr_q <= addr_q;
              mask_q     <= mask_init;
              state_q    <= INVAL;
            end else begin
              ready_q          <= grant_oh;
              d_out_q[grant_q] <= fb_out;
              state_q          <= RESP;
            end
          end
        end
        INVAL: begin
          // Acks are sticky; the entry cycle may already complete the set.
          mask_q <= mask_d;
          if (&mask_d) begin
            inv_q      <= '0;
            inv_addr_q <= '0;
            ready_q    <= grant_oh;
            state_q    <= RESP;
          end
        end
        RESP: begin
          ready_q <= '0;
          for (int i = 0; i < N_REQ; i++) d_out_q[i] <= '0;
          busy_q  <= 1'b0;
          ptr_q   <= (grant_q == core_id_t'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      ready[i]      = ready_q[i];
      invalidate[i] = inv_q[i];
      d_out[i]      = d_out_q[i];
    end
  end

  assign fb_en    = fb_en_q;
  assign fb_w     = fb_en_q & w_q;
  assign fb_addr  = fb_en_q ? addr_q : '0;
  assign fb_in    = fb_en_q ? din_q : '0;
  assign inv_addr = inv_addr_q;
  assign grant    = grant_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_l2_arbiter.sv
// Directed bench for l2_arbiter; honours L2ARB_SKIP_SELF_INV_EN when defined.
module tb_l2_arbiter;
  import cache_attrs::*;

  localparam int N = N_CORES;

  logic     clk = 1'b0;
  logic     rst;
  logic     en          [N];
  logic     w           [N];
  fb_addr_t addr        [N];
  fb_word_t d_in        [N];
  fb_word_t d_out       [N];
  logic     ready       [N];
  logic     invalidate  [N];
  fb_addr_t inv_addr;
  logic     invalidated [N];
  logic     fb_en, fb_w;
  fb_addr_t fb_addr;
  fb_word_t fb_in;
  fb_word_t fb_out;
  logic     fb_ready;
  core_id_t grant;
  logic     busy;

  logic [N-1:0] rdy_v, inv_v;
  int n_chk = 0;
  int n_err = 0;

  l2_arbiter #(.N_REQ(N), .RR_RESET(0)) dut (
    .clk(clk), .rst(rst), .en(en), .w(w), .addr(addr), .d_in(d_in),
    .d_out(d_out), .ready(ready), .invalidate(invalidate), .inv_addr(inv_addr),
    .invalidated(invalidated), .fb_en(fb_en), .fb_w(fb_w), .fb_addr(fb_addr),
    .fb_in(fb_in), .fb_out(fb_out), .fb_ready(fb_ready), .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    rdy_v = '0;
    inv_v = '0;
    for (int i = 0; i < N; i++) begin
      rdy_v[i] = ready[i];
      inv_v[i] = invalidate[i];
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fb(input string tag);
    int n = 0;
    while (fb_en !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    chk(tag, 64'(fb_en), 64'd1);
  endtask

  // Serve one read already requested by core k; fb answers lat cycles late.
  task automatic serve_read(input int k, input fb_addr_t a, input fb_word_t dat, input int lat);
    wait_fb("rd_fb_en");
    chk("rd_grant", 64'(grant), 64'(k));
    chk("rd_fb_w", 64'(fb_w), 64'd0);
    chk("rd_fb_addr", 64'(fb_addr), 64'(a));
    chk("rd_busy", 64'(busy), 64'd1);
    repeat (lat) cyc();
    fb_out = dat; fb_ready = 1'b1;
    cyc();
    fb_ready = 1'b0; fb_out = '0;
    chk("rd_ready", 64'(rdy_v), 64'(1 << k));
    chk("rd_d_out", d_out[k], dat);
    chk("rd_fb_en_drop", 64'(fb_en), 64'd0);
    en[k] = 1'b0;
    cyc();
    chk("rd_ready_pulse", 64'(rdy_v), 64'd0);
  endtask

  task automatic do_write(input int k, input fb_addr_t a, input fb_word_t dat,
                          input int o0, input int o1, input int o2);
    int ord[3];
    logic [N-1:0] need, got;
    bit done;
    ord = '{o0, o1, o2};
    en[k] = 1'b1; w[k] = 1'b1; addr[k] = a; d_in[k] = dat;
    wait_fb("wr_fb_en");
    chk("wr_grant", 64'(grant), 64'(k));
    chk("wr_fb_w", 64'(fb_w), 64'd1);
    chk("wr_fb_addr", 64'(fb_addr), 64'(a));
    chk("wr_fb_in", fb_in, dat);
    addr[k] = a ^ 16'h1; d_in[k] = ~dat;
    cyc();
    chk("wr_hold_addr", 64'(fb_addr), 64'(a));
    chk("wr_hold_data", fb_in, dat);
    fb_ready = 1'b1;
    cyc();
    fb_ready = 1'b0;
    need = '1;
`ifdef L2ARB_SKIP_SELF_INV_EN
    need[k] = 1'b0;
`endif
    chk("inv_vec", 64'(inv_v), 64'(need));
    chk("inv_addr", 64'(inv_addr), 64'(a));
    chk("wr_fb_en_drop", 64'(fb_en), 64'd0);
    got = '0; done = 1'b0;
    for (int j = 0; j < 3 && !done; j++) begin
      invalidated[ord[j]] = 1'b1;
      cyc();
      invalidated[ord[j]] = 1'b0;
      got[ord[j]] = 1'b1;
      if ((got & need) == need) begin
        done = 1'b1;
        chk("wr_ready", 64'(rdy_v), 64'(1 << k));
        chk("wr_d_out", d_out[k], 64'd0);
        chk("inv_drop", 64'(inv_v), 64'd0);
      end else begin
        chk("wr_ready_early", 64'(rdy_v), 64'd0);
        chk("inv_held", 64'(inv_v), 64'(need));
      end
    end
    en[k] = 1'b0; w[k] = 1'b0;
    cyc();
    chk("wr_ready_pulse", 64'(rdy_v), 64'd0);
    chk("wr_busy_end", 64'(busy), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
  endtask

  initial begin
    int bursts;
    rst = 1'b1; fb_out = '0; fb_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      en[i] = 1'b0; w[i] = 1'b0; addr[i] = '0; d_in[i] = '0; invalidated[i] = 1'b0;
    end
    #2 rst = 1'b0;
    #1;
    chk("rst_fb_en", 64'(fb_en), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_ready", 64'(rdy_v), 64'd0);
    chk("rst_inv", 64'(inv_v), 64'd0);
    cyc();
    rst = 1'b1;
    cyc();

    // 1: single read, fb_en one cycle after the request
    en[0] = 1'b1; w[0] = 1'b0; addr[0] = 16'd17;
    cyc();
    chk("t1_latency", 64'(fb_en), 64'd1);
    serve_read(0, 16'd17, 64'h6768697071727374, 2);

    // 2: write from core 1, acks 2,0,1
    do_write(1, 16'd243, 64'hdeadbeeffeddeeda, 2, 0, 1);

    // 3: concurrent reads from a fresh pointer
    do_reset();
    en[0] = 1'b1; addr[0] = 16'd123;
    en[1] = 1'b1; addr[1] = 16'd321;
    en[2] = 1'b1; addr[2] = 16'd555;
    bursts = 0;
    serve_read(0, 16'd123, 64'd123, 1); bursts++;
    serve_read(1, 16'd321, 64'd321, 0); bursts++;
    serve_read(2, 16'd555, 64'd555, 2); bursts++;
    repeat (3) cyc();
    chk("t3_idle_fb_en", 64'(fb_en), 64'd0);
    chk("t3_bursts", 64'(bursts), 64'd3);

    // 4: pointer moved to 1 by a read from core 0, then 0 and 2 compete
    en[0] = 1'b1; addr[0] = 16'd7;
    serve_read(0, 16'd7, 64'h1111, 0);
    en[0] = 1'b1; addr[0] = 16'd40;
    en[2] = 1'b1; addr[2] = 16'd42;
    serve_read(2, 16'd42, 64'h2222, 1);
    serve_read(0, 16'd40, 64'h3333, 1);

    // 5: reset while fb is in flight
    en[1] = 1'b1; w[1] = 1'b0; addr[1] = 16'd5;
    wait_fb("t5_fb_en");
    chk("t5_grant", 64'(grant), 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("t5_fb_en", 64'(fb_en), 64'd0);
    chk("t5_fb_addr", 64'(fb_addr), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_grant_rst", 64'(grant), 64'd0);
    en[1] = 1'b0;
    cyc();
    rst = 1'b1;
    fb_out = 64'hbad; fb_ready = 1'b1;
    cyc();
    fb_ready = 1'b0; fb_out = '0;
    for (int i = 0; i < 3; i++) begin
      chk("t5_no_ready", 64'(rdy_v), 64'd0);
      chk("t5_no_busy", 64'(busy), 64'd0);
      cyc();
    end

    // 6: write from core 2; acks 1,0,2
    do_write(2, 16'd99, 64'h0123456789abcdef, 1, 0, 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1);
  end

endmodule
